vga_hvsync_gen: RTL and testbench
=================================

// Module: vga_hvsync_gen
// PURPOSE
//   VGA raster timing generator for 640x480 at 60 Hz.
//   Counts pixels per line and lines per frame on the pixel clock.
//   Drives active-low horizontal and vertical sync, plus a display-area qualifier.
//   Exports the current X/Y beam position.
//   Sits between the clock divider and the pixel/colour logic, which registers RGB as colour & inDisplayArea.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   horizontal sync pulse width (pixels)
//   H_BP      48   horizontal back porch; H_TOTAL = 800
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vertical sync pulse width (lines)
//   V_BP      33   vertical back porch; V_TOTAL = 525
//   CNT_W     10   width of CounterX/CounterY
// PORTS
//   clk            in   1      pixel clock; one pixel per rising edge
//   reset          in   1      asynchronous, active-low (0 = reset asserted)
//   vga_h_sync     out  1      horizontal sync, active low
//   vga_v_sync     out  1      vertical sync, active low
//   inDisplayArea  out  1      1 when (CounterX,CounterY) is inside the visible 640x480 window
//   CounterX       out  CNT_W  current pixel column, 0..H_TOTAL-1
//   CounterY       out  CNT_W  current line, 0..V_TOTAL-1
// BEHAVIOUR
//   Reset (reset==0, async, takes effect immediately):
//   - CounterX=0, CounterY=0, vga_h_sync=1, vga_v_sync=1, inDisplayArea=1.
//   - Counting resumes on the first rising clk edge after reset returns to 1.
//   Horizontal counter:
//   - CounterX increments by 1 every clk.
//   - At CounterX==H_TOTAL-1 (799), CounterX wraps to 0 on the next edge.
//   Vertical counter:
//   - CounterY increments only on the edge where CounterX wraps.
//   - At CounterY==V_TOTAL-1 (524) with CounterX==799, CounterY wraps to 0.
//   - Result: frame period is 800*525 = 420000 clk.
//   Decode (all outputs registered, aligned with the counters; no cycle of skew):
//   - vga_h_sync = 0 iff H_ACTIVE+H_FP <= CounterX < H_ACTIVE+H_FP+H_SYNC (656..751).
//   - vga_v_sync = 0 iff V_ACTIVE+V_FP <= CounterY < V_ACTIVE+V_FP+V_SYNC (490..491).
//   - inDisplayArea = (CounterX < 640) && (CounterY < 480).
//   Implementation: compute next X/Y combinationally, then register counters and decodes from next values.
//   Counters never exceed TOTAL-1; out-of-range values are impossible after reset.
//   Unsigned arithmetic throughout; widths are sized so 799/524 fit in CNT_W.
//   Reset mid-frame: returns instantly to the reset values above; the frame restarts at (0,0).
//   No enables, no handshakes; free-running whenever reset==1.
// TESTING
//   1. Reset: hold reset=0 for 3 clk -> CounterX=0, CounterY=0, h/v sync=1, inDisplayArea=1.
//      Release -> after 1 clk CounterX=1.
//   2. Line wrap: run 799 clk from (0,0) -> CounterX=799, CounterY=0.
//      Next clk -> CounterX=0, CounterY=1.
//   3. Hsync window: vga_h_sync=1 at X=655, 0 at X=656 and X=751, 1 at X=752.
//      Verify this on every line.
//   4. Vsync/frame: vga_v_sync=0 exactly for lines 490..491 (1600 clk).
//      (799,524) -> (0,0); vga_v_sync falling edges are 420000 clk apart.
//   5. Display area: inDisplayArea=1 at (639,479), 0 at (640,0) and (0,480).
//      Count of 1s per frame = 307200.
//   6. Async reset mid-frame: drive reset=0 at (300,200) between clk edges.
//      Counters go to 0 immediately, without a clk edge; recovery follows scenario 1.

Source files
------------

// File: rtl/vga_hvsync_gen.sv
// VGA raster timing generator (640x480 @ 60 Hz by default): pixel/line counters,
// active-low h/v sync and a display-area qualifier, all registered and aligned.
module vga_hvsync_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned CNT_W    = 10
) (
   input  logic             clk,
   input  logic             reset,
   output logic             vga_h_sync,
   output logic             vga_v_sync,
   output logic             inDisplayArea,
   output logic [CNT_W-1:0] CounterX,
   output logic [CNT_W-1:0] CounterY
);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t H_LAST       = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t H_VIS        = cnt_t'(H_ACTIVE);
   localparam cnt_t H_SYNC_START = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t H_SYNC_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t V_LAST       = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam cnt_t V_VIS        = cnt_t'(V_ACTIVE);
   localparam cnt_t V_SYNC_START = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t V_SYNC_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

   cnt_t x_q, x_d;
   cnt_t y_q, y_d;
   logic hs_q, hs_d;
   logic vs_q, vs_d;
   logic de_q, de_d;

   // Decodes are taken from the next-state counters so they land on the same
   // edge as the counters themselves, with no cycle of skew.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      x_d = x_q + cnt_t'(1);
      y_d = y_q;
      if (x_q == H_LAST) begin
         x_d = '0;
         if (y_q == V_LAST) y_d = '0;
         else               y_d = y_q + cnt_t'(1);
      end
      hs_d = !((x_d >= H_SYNC_START) && (x_d < H_SYNC_END));
      vs_d = !((y_d >= V_SYNC_START) && (y_d < V_SYNC_END));
      de_d = (x_d < H_VIS) && (y_d < V_VIS);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q  <= '0;
         y_q  <= '0;
         hs_q <= 1'b1;
         vs_q <= 1'b1;
         de_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         x_q  <= x_d;
         y_q  <= y_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
      end
   end

   assign CounterX      = x_q;
   assign CounterY      = y_q;
   assign vga_h_sync    = hs_q;
   assign vga_v_sync    = vs_q;
   assign inDisplayArea = de_q;

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Bench for vga_hvsync_gen: a full-size instance for line-level timing and a
// shrunken instance (16x12 raster) so whole frames fit in a short run.
module tb_vga_hvsync_gen;

   logic       clk;
   logic       reset_a;
   logic       reset_b;
   logic       hs_a, vs_a, de_a;
   logic [9:0] cx_a, cy_a;
   logic       hs_b, vs_b, de_b;
   logic [9:0] cx_b, cy_b;

   int total;
   int bad;

   vga_hvsync_gen dut_a (
      .clk           (clk),
      .reset         (reset_a),
      .vga_h_sync    (hs_a),
      .vga_v_sync    (vs_a),
      .inDisplayArea (de_a),
      .CounterX      (cx_a),
      .CounterY      (cy_a)
   );

   // Small raster: H 8+2+3+3=16 (hsync low X 10..12), V 6+2+2+2=12 (vsync low Y 8..9).
   vga_hvsync_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
      .CNT_W    (10)
   ) dut_b (
      .clk           (clk),
      .reset         (reset_b),
      .vga_h_sync    (hs_b),
      .vga_v_sync    (vs_b),
      .inDisplayArea (de_b),
      .CounterX      (cx_b),
      .CounterY      (cy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      tick(3);
      total++; if (cx_a !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", cx_a); end
      total++; if (cy_a !== 10'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", cy_a); end
      total++; if ({hs_a, vs_a, de_a} !== 3'b111) begin bad++; $display("FAIL reset_flags got=%b exp=111", {hs_a, vs_a, de_a}); end
      total++; if ({cx_b, cy_b, hs_b, vs_b, de_b} !== {20'd0, 3'b111}) begin bad++; $display("FAIL reset_small got=%0d,%0d,%b exp=0,0,111", cx_b, cy_b, {hs_b, vs_b, de_b}); end
      reset_a = 1'b1;
      tick(1);
      total++; if (cx_a !== 10'd1 || cy_a !== 10'd0) begin bad++; $display("FAIL release_x got=(%0d,%0d) exp=(1,0)", cx_a, cy_a); end
   endtask

   task automatic test_line_wrap;
      tick(798);
      total++; if (cx_a !== 10'd799 || cy_a !== 10'd0) begin bad++; $display("FAIL at_799 got=(%0d,%0d) exp=(799,0)", cx_a, cy_a); end
      total++; if (hs_a !== 1'b1 || de_a !== 1'b0) begin bad++; $display("FAIL at_799_flags got=hs%b de%b exp=hs1 de0", hs_a, de_a); end
      tick(1);
      total++; if (cx_a !== 10'd0 || cy_a !== 10'd1) begin bad++; $display("FAIL wrap got=(%0d,%0d) exp=(0,1)", cx_a, cy_a); end
      total++; if (hs_a !== 1'b1 || de_a !== 1'b1) begin bad++; $display("FAIL wrap_flags got=hs%b de%b exp=hs1 de1", hs_a, de_a); end
   endtask

   // Starts at (0,1); walks three full lines checking sync window and display edge.
   task automatic test_hsync_lines;
      for (int line = 1; line <= 3; line++) begin
         int lows;
         lows = 0;
         for (int c = 0; c < 800; c++) begin
            if (c == 639) begin
               total++; if (de_a !== 1'b1) begin bad++; $display("FAIL de_639 line=%0d got=%b exp=1", line, de_a); end
            end
            if (c == 640) begin
               total++; if (de_a !== 1'b0) begin bad++; $display("FAIL de_640 line=%0d got=%b exp=0", line, de_a); end
            end
            if (c == 655) begin
               total++; if (hs_a !== 1'b1 || cx_a !== 10'd655 || cy_a !== 10'(line)) begin bad++; $display("FAIL hs_655 line=%0d got=hs%b x%0d y%0d exp=hs1 x655", line, hs_a, cx_a, cy_a); end
            end
            if (c == 656) begin
               total++; if (hs_a !== 1'b0) begin bad++; $display("FAIL hs_656 line=%0d got=%b exp=0", line, hs_a); end
            end
            if (c == 751) begin
               total++; if (hs_a !== 1'b0) begin bad++; $display("FAIL hs_751 line=%0d got=%b exp=0", line, hs_a); end
            end
            if (c == 752) begin
               total++; if (hs_a !== 1'b1) begin bad++; $display("FAIL hs_752 line=%0d got=%b exp=1", line, hs_a); end
            end
            if (hs_a === 1'b0) lows++;
            if (vs_a !== 1'b1) begin
               total++; bad++; $display("FAIL vs_early line=%0d x=%0d got=%b exp=1", line, c, vs_a);
            end
            tick(1);
         end
         total++; if (lows != 96) begin bad++; $display("FAIL hs_width line=%0d got=%0d exp=96", line, lows); end
      end
   endtask

   // Starts at (0,4).
   task automatic test_async_reset_big;
      tick(300);
      total++; if (cx_a !== 10'd300 || cy_a !== 10'd4) begin bad++; $display("FAIL pre_reset got=(%0d,%0d) exp=(300,4)", cx_a, cy_a); end
      reset_a = 1'b0;
      #1;
      total++; if (cx_a !== 10'd0 || cy_a !== 10'd0 || {hs_a, vs_a, de_a} !== 3'b111) begin bad++; $display("FAIL async_reset got=(%0d,%0d) %b exp=(0,0) 111", cx_a, cy_a, {hs_a, vs_a, de_a}); end
      tick(3);
      total++; if (cx_a !== 10'd0) begin bad++; $display("FAIL reset_hold got=%0d exp=0", cx_a); end
      reset_a = 1'b1;
      tick(1);
      total++; if (cx_a !== 10'd1 || cy_a !== 10'd0) begin bad++; $display("FAIL recover got=(%0d,%0d) exp=(1,0)", cx_a, cy_a); end
   endtask

   task automatic test_small_frames;
      int vs_lows, hs_lows, de_ones, fall1, fall2;
      logic prev_vs;
      reset_b = 1'b1;
      tick(1);
      total++; if (cx_b !== 10'd1 || cy_b !== 10'd0) begin bad++; $display("FAIL s_release got=(%0d,%0d) exp=(1,0)", cx_b, cy_b); end
      tick(190);
      total++; if (cx_b !== 10'd15 || cy_b !== 10'd11) begin bad++; $display("FAIL s_last got=(%0d,%0d) exp=(15,11)", cx_b, cy_b); end
      tick(1);
      total++; if (cx_b !== 10'd0 || cy_b !== 10'd0) begin bad++; $display("FAIL s_frame_wrap got=(%0d,%0d) exp=(0,0)", cx_b, cy_b); end
      vs_lows = 0; hs_lows = 0; de_ones = 0; fall1 = -1; fall2 = -1;
      prev_vs = 1'b1;
      for (int i = 0; i < 384; i++) begin
         int ex, ey;
         ex = i % 16;
         ey = (i / 16) % 12;
         if (cx_b !== 10'(ex) || cy_b !== 10'(ey)) begin
            total++; bad++; $display("FAIL s_pos i=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, cx_b, cy_b, ex, ey);
         end
         if (ex == 9 || ex == 13) begin
            total++; if (hs_b !== 1'b1) begin bad++; $display("FAIL s_hs_edge_hi x=%0d y=%0d got=%b exp=1", ex, ey, hs_b); end
         end
         if (ex == 10 || ex == 12) begin
            total++; if (hs_b !== 1'b0) begin bad++; $display("FAIL s_hs_edge_lo x=%0d y=%0d got=%b exp=0", ex, ey, hs_b); end
         end
         if (i == 7*16+15 || i == 10*16) begin
            total++; if (vs_b !== 1'b1) begin bad++; $display("FAIL s_vs_hi i=%0d got=%b exp=1", i, vs_b); end
         end
         if (i == 8*16 || i == 9*16+15) begin
            total++; if (vs_b !== 1'b0) begin bad++; $display("FAIL s_vs_lo i=%0d got=%b exp=0", i, vs_b); end
         end
         if (i == 5*16+7) begin
            total++; if (de_b !== 1'b1) begin bad++; $display("FAIL s_de_corner got=%b exp=1", de_b); end
         end
         if (i == 8 || i == 6*16) begin
            total++; if (de_b !== 1'b0) begin bad++; $display("FAIL s_de_out i=%0d got=%b exp=0", i, de_b); end
         end
         if (i < 192) begin
            if (vs_b === 1'b0) vs_lows++;
            if (hs_b === 1'b0) hs_lows++;
            if (de_b === 1'b1) de_ones++;
         end
         if (prev_vs === 1'b1 && vs_b === 1'b0) begin
            if (fall1 < 0) fall1 = i;
            else if (fall2 < 0) fall2 = i;
         end
         prev_vs = vs_b;
         tick(1);
      end
      total++; if (vs_lows != 32) begin bad++; $display("FAIL s_vs_width got=%0d exp=32", vs_lows); end
      total++; if (hs_lows != 36) begin bad++; $display("FAIL s_hs_total got=%0d exp=36", hs_lows); end
      total++; if (de_ones != 48) begin bad++; $display("FAIL s_de_count got=%0d exp=48", de_ones); end
      total++; if (fall1 != 128) begin bad++; $display("FAIL s_vs_fall1 got=%0d exp=128", fall1); end
      total++; if (fall2 - fall1 != 192) begin bad++; $display("FAIL s_vs_period got=%0d exp=192", fall2 - fall1); end
   endtask

   // Starts at (0,0) of the small raster; scaled mid-frame reset.
   task automatic test_small_async_reset;
      tick(53);
      total++; if (cx_b !== 10'd5 || cy_b !== 10'd3) begin bad++; $display("FAIL s_pre_reset got=(%0d,%0d) exp=(5,3)", cx_b, cy_b); end
      reset_b = 1'b0;
      #1;
      total++; if (cx_b !== 10'd0 || cy_b !== 10'd0 || {hs_b, vs_b, de_b} !== 3'b111) begin bad++; $display("FAIL s_async_reset got=(%0d,%0d) %b exp=(0,0) 111", cx_b, cy_b, {hs_b, vs_b, de_b}); end
      tick(3);
      reset_b = 1'b1;
      tick(1);
      total++; if (cx_b !== 10'd1 || cy_b !== 10'd0) begin bad++; $display("FAIL s_recover got=(%0d,%0d) exp=(1,0)", cx_b, cy_b); end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset_a = 1'b0;
      reset_b = 1'b0;
      test_reset();
      test_line_wrap();
      test_hsync_lines();
      test_async_reset_big();
      test_small_frames();
      test_small_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
